bus_seq_datapath: RTL and testbench
===================================

// Module: bus_seq_datapath
// PURPOSE
//  Parametrised single-bus datapath with a built-in T-state microsequencer. Holds NUM_REGS GP registers plus Y, Z(hi/lo), HI, LO and MDR.
//  Register moves share one internal bus, exactly one driver per cycle, chosen from sequencer state.
//  Executes one register-to-register ALU op, MUL or memory load per start pulse. Uses a req/ack memory-read handshake.
//  Generalises the fixed 16x32 strobe-driven datapath: width and depth are parameters; the control strobes are sequenced internally.
// PARAMETERS
//  DATA_W    32  bus/register width (>=8)
//  NUM_REGS  16  GP register count, power of 2 (>=2)
//  REG_AW    $clog2(NUM_REGS)  register address width (derived, do not override)
// PORTS
//  clk        in   1          clock, all state updates on posedge
//  clr        in   1          synchronous active-high reset
//  start      in   1          launch op; sampled only in IDLE
//  op         in   3          0 ADD,1 SUB,2 AND,3 OR,4 SHL,5 SHR,6 MUL,7 LDM
//  ra,rb,rc   in   REG_AW     src A, src B, dest register
//  mem_rd     out  1          memory read request (LDM)
//  mem_ack    in   1          memory data valid
//  mdata_in   in   DATA_W     memory read data
//  busy       out  1          state != IDLE
//  done       out  1          registered 1-cycle completion pulse
//  bus_out    out  DATA_W     current internal bus value (0 when undriven)
//  hi_out,lo_out out DATA_W   HI/LO registers
//  dbg_addr   in   REG_AW     debug read address
//  dbg_data   out  DATA_W     combinational R[dbg_addr]
// BEHAVIOUR
//  Reset (clr=1 at posedge): state IDLE; all R[], Y, Z, HI, LO, MDR = 0; done=0, mem_rd=0. Any in-flight op is abandoned, nothing written.
//  Start in IDLE: op/ra/rb/rc are latched. start while busy is ignored, and latched fields do not change.
//  ALU ops (0-5) run T0 -> T1 -> T2 -> IDLE:
//    T0: bus=R[ra]; Y<=bus.
//    T1: bus=R[rb]; Z<=ALU(Y,bus).
//    T2: bus=Zlo; R[rc]<=bus.
//    busy is high for 3 cycles; done=1 in the cycle after T2, and the result is then visible on dbg_data.
//  MUL runs T0 -> T1 -> T2 -> T3 -> IDLE:
//    T1: Z<=Y*bus, unsigned, full 2*DATA_W product.
//    T2: bus=Zlo; LO<=bus.
//    T3: bus=Zhi; HI<=bus. R[rc] is not written.
//  LDM runs M0 -> M1 -> IDLE:
//    M0: mem_rd=1, held until mem_ack is sampled 1; MDR<=mdata_in at that edge; then go to M1. No timeout.
//    M1: bus=MDR; R[rc]<=bus.
//  mem_rd is 0 in all other states. mem_ack outside M0 is ignored.
//  ALU arithmetic:
//    ADD/SUB wrap mod 2^DATA_W.
//    SHL/SHR are logical, shift amount = bus[$clog2(DATA_W)-1:0].
//    Zhi = 0 for every non-MUL op.
//  ra==rb==rc is legal: reads happen in T0/T1 before the write in T2.
//  done and start in the same cycle: start is accepted, since the sequencer is already IDLE.
//  IDLE: bus undriven (bus_out=0), no register writes.
//  dbg_data reflects a write on the cycle after the write edge.
// TESTING
//  1 Reset: preload regs via LDM, assert clr 1 cycle -> all dbg reads 0, hi/lo 0, busy 0, done 0.
//  2 ADD wrap: LDM R1=0xFFFFFFFF, R2=0x2; ADD ra=1 rb=2 rc=3 -> busy for 3 cycles, done pulse, R3=0x00000001. SUB 1-2 -> 0xFFFFFFFF.
//  3 MUL: R4=0x00010000, R5=0x00010000; MUL -> 4 busy cycles, HI=0x1, LO=0x0, R[rc] unchanged.
//  4 LDM handshake: mem_ack delayed 3 cycles, mdata_in=0xDEADBEEF, rc=7 -> mem_rd high for 4 cycles, R7=0xDEADBEEF, done 2 cycles after ack edge.
//  5 Abort/ignore: clr asserted during T1 of ADD into R3=0x55 -> R3=0, state IDLE, no done. start during busy -> ignored, exactly one done.
//  6 Shift/alias: R6=0x80000001; SHL ra=rb=rc=6 with shift amount 1 -> R6=0x00000002. Back-to-back start in the done cycle is accepted.

Source files
------------

// File: rtl/bus_seq_datapath.sv
// bus_seq_datapath: single-bus register datapath with an internal T-state microsequencer
module bus_seq_datapath #(
    parameter  int DATA_W   = 32,
    parameter  int NUM_REGS = 16,
    localparam int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [REG_AW-1:0] ra,
    input  logic [REG_AW-1:0] rb,
    input  logic [REG_AW-1:0] rc,
    output logic              mem_rd,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mdata_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] bus_out,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int SW = $clog2(DATA_W);
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3;
    localparam logic [2:0] OP_SHL = 3'd4, OP_MUL = 3'd6, OP_LDM = 3'd7;

    typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_T3, S_M0, S_M1} state_t;

    state_t              state_q;
    logic [2:0]          op_q;
    logic [REG_AW-1:0]   ra_q, rb_q, rc_q;
    logic [DATA_W-1:0]   r_q [NUM_REGS];
    logic [DATA_W-1:0]   y_q, mdr_q, hi_q, lo_q;
    logic [2*DATA_W-1:0] z_q, z_d;
    logic                done_q;
    logic [DATA_W-1:0]   bus, alu;
    logic [2*DATA_W-1:0] prod;

    assign bus = state_q == S_T0 ? r_q[ra_q] :
                 state_q == S_T1 ? r_q[rb_q] :
                 state_q == S_T2 ? z_q[DATA_W-1:0] :
                 state_q == S_T3 ? z_q[2*DATA_W-1:DATA_W] :
                 state_q == S_M1 ? mdr_q : '0;

    assign prod = {{DATA_W{1'b0}}, y_q} * {{DATA_W{1'b0}}, bus};

    // ALU result for the T1 cycle; Zhi is only populated by MUL
    always_comb begin
        alu = op_q == OP_ADD ? y_q + bus :
              op_q == OP_SUB ? y_q - bus :
              op_q == OP_AND ? y_q & bus :
              op_q == OP_OR  ? y_q | bus :
              op_q == OP_SHL ? y_q << bus[SW-1:0] : y_q >> bus[SW-1:0];
        z_d = op_q == OP_MUL ? prod : {{DATA_W{1'b0}}, alu};
    end

    // Sequencer and all register transfers; one bus driver per state
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            y_q     <= '0;
            z_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mdr_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) r_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    op_q    <= op;
                    ra_q    <= ra;
                    rb_q    <= rb;
                    rc_q    <= rc;
                    state_q <= op == OP_LDM ? S_M0 : S_T0;
                end
                S_T0: begin
                    y_q     <= bus;
                    state_q <= S_T1;
                end
                S_T1: begin
                    z_q     <= z_d;
                    state_q <= S_T2;
                end
                S_T2: if (op_q == OP_MUL) begin
                    lo_q    <= bus;
                    state_q <= S_T3;
                end else begin
                    r_q[rc_q] <= bus;
                    done_q    <= 1'b1;
                    state_q   <= S_IDLE;
                end
                S_T3: begin
                    hi_q    <= bus;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                S_M0: if (mem_ack) begin
                    mdr_q   <= mdata_in;
                    state_q <= S_M1;
                end
                S_M1: begin
                    r_q[rc_q] <= bus;
                    done_q    <= 1'b1;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = state_q != S_IDLE;
    assign mem_rd   = state_q == S_M0;
    assign done     = done_q;
    assign bus_out  = bus;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign dbg_data = r_q[dbg_addr];
endmodule

// File: tb/tb_bus_seq_datapath.sv
// tb_bus_seq_datapath: directed self-checking bench for bus_seq_datapath
module tb_bus_seq_datapath;
    logic        clk = 1'b0, clr = 1'b1, start = 1'b0, mem_ack = 1'b0;
    logic [2:0]  op = '0;
    logic [3:0]  ra = '0, rb = '0, rc = '0, dbg_addr = '0;
    logic [31:0] mdata_in = '0;
    logic        mem_rd, busy, done;
    logic [31:0] bus_out, hi_out, lo_out, dbg_data;
    int          n_chk = 0, n_err = 0;
    int          rd_n, done_n, nb, nd;

    bus_seq_datapath #(.DATA_W(32), .NUM_REGS(16)) dut (
        .clk(clk), .clr(clr), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
        .mem_rd(mem_rd), .mem_ack(mem_ack), .mdata_in(mdata_in), .busy(busy), .done(done),
        .bus_out(bus_out), .hi_out(hi_out), .lo_out(lo_out), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
        dbg_addr = a;
        #1 chk(tag, dbg_data, exp);
    endtask

    // memory load into R[c] with dly idle cycles before ack
    task automatic ldm(input logic [3:0] c, input logic [31:0] d, input int dly);
        @(negedge clk) begin start = 1'b1; op = 3'd7; rc = c; end
        @(negedge clk) start = 1'b0;
        rd_n = 0;
        done_n = 0;
        for (int i = 0; i < dly; i++) begin
            rd_n += int'(mem_rd);
            @(negedge clk);
        end
        rd_n += int'(mem_rd);
        mem_ack = 1'b1;
        mdata_in = d;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) mem_ack = 1'b0;
            rd_n += int'(mem_rd);
            if (done && done_n == 0) done_n = k;
        end
    endtask

    task automatic run(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        @(negedge clk) begin start = 1'b1; op = o; ra = a; rb = b; rc = c; end
        @(negedge clk) start = 1'b0;
        nb = 0;
        nd = 0;
        for (int k = 0; k < 8; k++) begin
            nb += int'(busy);
            nd += int'(done);
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk) clr = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_memrd", mem_rd, 0);
        chk("rst_bus", bus_out, 0);

        // 1: preload, then reset clears everything
        ldm(4'd1, 32'h12345678, 0);
        ldm(4'd2, 32'h00000100, 0);
        ldm(4'd15, 32'h000000AB, 1);
        run(3'd6, 4'd1, 4'd2, 4'd0);
        chk("pre_hi", hi_out, 32'h12);
        chk("pre_lo", lo_out, 32'h34567800);
        rd(4'd15, 32'hAB, "pre_r15");
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        for (int i = 0; i < 16; i++) rd(4'(i), 32'h0, "clr_reg");
        chk("clr_hi", hi_out, 0);
        chk("clr_lo", lo_out, 0);
        chk("clr_busy", busy, 0);
        chk("clr_done", done, 0);

        // 2: ADD wrap and SUB underflow
        ldm(4'd1, 32'hFFFFFFFF, 0);
        ldm(4'd2, 32'h00000002, 0);
        run(3'd0, 4'd1, 4'd2, 4'd3);
        chk("add_busy", nb, 3);
        chk("add_done", nd, 1);
        rd(4'd3, 32'h00000001, "add_r3");
        run(3'd1, 4'd3, 4'd2, 4'd12);
        rd(4'd12, 32'hFFFFFFFF, "sub_r12");

        // 3: MUL into HI/LO, R[rc] untouched
        ldm(4'd4, 32'h00010000, 0);
        ldm(4'd5, 32'h00010000, 0);
        ldm(4'd11, 32'h00000077, 0);
        run(3'd6, 4'd4, 4'd5, 4'd11);
        chk("mul_busy", nb, 4);
        chk("mul_done", nd, 1);
        chk("mul_hi", hi_out, 32'h1);
        chk("mul_lo", lo_out, 32'h0);
        rd(4'd11, 32'h77, "mul_rc");

        // 4: LDM with delayed ack
        ldm(4'd7, 32'hDEADBEEF, 3);
        chk("ldm_rd_cycles", rd_n, 4);
        chk("ldm_done_lat", done_n, 2);
        rd(4'd7, 32'hDEADBEEF, "ldm_r7");

        // 5a: clr during T1 abandons the op
        ldm(4'd1, 32'h50, 0);
        ldm(4'd2, 32'h05, 0);
        @(negedge clk) begin start = 1'b1; op = 3'd0; ra = 4'd1; rb = 4'd2; rc = 4'd3; end
        @(negedge clk) start = 1'b0;
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        chk("abort_busy", busy, 0);
        nd = 0;
        for (int k = 0; k < 4; k++) begin
            nd += int'(done);
            @(negedge clk);
        end
        chk("abort_done", nd, 0);
        rd(4'd3, 32'h0, "abort_r3");

        // 5b: start while busy is ignored
        ldm(4'd1, 32'h10, 0);
        ldm(4'd2, 32'h20, 0);
        @(negedge clk) begin start = 1'b1; op = 3'd0; ra = 4'd1; rb = 4'd2; rc = 4'd3; end
        @(negedge clk) start = 1'b0;
        @(negedge clk) begin start = 1'b1; op = 3'd1; ra = 4'd2; rb = 4'd1; rc = 4'd8; end
        @(negedge clk) start = 1'b0;
        nd = 0;
        for (int k = 0; k < 8; k++) begin
            nd += int'(done);
            @(negedge clk);
        end
        chk("ign_done", nd, 1);
        rd(4'd3, 32'h30, "ign_r3");
        rd(4'd8, 32'h0, "ign_r8");

        // 6: aliased SHL, then back-to-back start in the done cycle
        ldm(4'd6, 32'h80000001, 0);
        @(negedge clk) begin start = 1'b1; op = 3'd4; ra = 4'd6; rb = 4'd6; rc = 4'd6; end
        @(negedge clk) start = 1'b0;
        chk("shl_bus_t0", bus_out, 32'h80000001);
        @(negedge clk);
        @(negedge clk) chk("shl_bus_t2", bus_out, 32'h00000002);
        @(negedge clk) chk("shl_done", done, 1);
        start = 1'b1; op = 3'd0; ra = 4'd6; rb = 4'd6; rc = 4'd10;
        @(negedge clk) start = 1'b0;
        chk("b2b_busy", busy, 1);
        rd(4'd6, 32'h00000002, "shl_r6");
        nd = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            nd += int'(done);
        end
        chk("b2b_done", nd, 1);
        rd(4'd10, 32'h00000004, "b2b_r10");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
